result_fifo: RTL and testbench

RESULT_FIFO -- requirements
Module: result_fifo

---
 rtl/result_fifo.sv | 118 +++++++++++
 tb/tb_result_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_fifo.sv
// result_fifo: small synchronous FIFO that buffers results from the adder
// pipeline until the consumer takes them.
//
// Behaviour summary:
//   - push when in_valid && in_ready, pop when out_valid && out_ready
//   - one cycle from push to visibility, no fall-through path
//   - a push into a full FIFO is dropped and sets the sticky overflow flag,
//     even if a pop happens in the same cycle
//   - clr empties the FIFO and clears overflow, overriding push and pop
//   - out_data reads as zero whenever the FIFO is empty, so stale storage
//     contents are never visible
//
// Optional feature, enabled by defining RESULT_FIFO_ACCUM_EN:
//   adds a 16-bit output 'acc' holding the wrapping sum of every popped
//   out_data value; it is cleared by reset and by clr.

module result_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     flush_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef RESULT_FIFO_ACCUM_EN
    ,
    output logic [15:0]              acc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    // clr wins over both handshakes, so neither push nor pop fires with it
    assign push = in_valid && !full && !clr;
    assign pop  = out_valid && out_ready && !clr;

    // Head entry is masked to zero when empty so storage never leaks out
    assign out_data = empty ? '0 : mem[rd_ptr];

    // Storage array: written on push only, never reset (masked when empty)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: set whenever a result arrives while full
    always_ff @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef RESULT_FIFO_ACCUM_EN
    // Running sum of popped values, zero-extended and wrapping at 16 bits
    always_ff @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (pop) begin
            acc <= acc + 16'(out_data);
        end
    end
`endif

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: self-checking bench for result_fifo.
// Mixes a table of fill/drain/overflow vectors, hand-written sequences for
// reset, simultaneous push/pop and clear priority, and a randomized run
// compared against a queue-based reference model.

module tb_result_fifo;

    localparam int WIDTH = 9;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             flush_n;
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;
`ifdef RESULT_FIFO_ACCUM_EN
    logic [15:0]      acc;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf = 1'b0;
    logic [15:0]      model_acc = '0;

    typedef struct {
        logic             clr;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        int               e_count;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic             e_ready;
        logic             e_ovf;
    } vec_t;

    vec_t vecs[10];

    result_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .flush_n  (flush_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow)
`ifdef RESULT_FIFO_ACCUM_EN
        ,
        .acc      (acc)
`endif
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int n;
        logic pushing;
        logic popping;
        n = model_q.size();
        if (clr) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_acc = '0;
        end else begin
            pushing = in_valid && (n < DEPTH);
            popping = out_ready && (n > 0);
            if (in_valid && (n == DEPTH)) model_ovf = 1'b1;
            if (popping) begin
                model_acc = model_acc + 16'(model_q[0]);
                void'(model_q.pop_front());
            end
            if (pushing) model_q.push_back(in_data);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_acc = '0;
    endtask

    task automatic apply_stimulus(input logic c, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        clr       = c;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_output(input string tag);
        logic [WIDTH-1:0] head;
        int n;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        check_val({tag, ".count"},     32'(count),     32'(n));
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        check_val({tag, ".out_data"},  32'(out_data),  32'(head));
        check_val({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
        check_val({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
`ifdef RESULT_FIFO_ACCUM_EN
        check_val({tag, ".acc"},       32'(acc),       32'(model_acc));
`endif
    endtask

    initial begin
        // Fill four, overflow attempt while popping, drain, empty pop, clear
        vecs[0] = '{1'b0, 1'b1, 9'h001, 1'b0, 1, 1'b1, 9'h001, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 9'h0FF, 1'b0, 2, 1'b1, 9'h001, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 9'h1FE, 1'b0, 3, 1'b1, 9'h001, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 9'h100, 1'b0, 4, 1'b1, 9'h001, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 9'h055, 1'b1, 3, 1'b1, 9'h0FF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 9'h000, 1'b1, 2, 1'b1, 9'h1FE, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 9'h000, 1'b1, 1, 1'b1, 9'h100, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 9'h000, 1'b1, 0, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 9'h000, 1'b1, 0, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 9'h000, 1'b0, 0, 1'b0, 9'h000, 1'b1, 1'b0};

        flush_n   = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.count",    32'(count),     32'd0);
        check_val("reset.in_ready", 32'(in_ready),  32'd1);
        check_val("reset.overflow", 32'(overflow),  32'd0);
        @(negedge clk);
        flush_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset");

        // Table-driven fill/drain/overflow/clear
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check_val($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_count));
            check_val($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check_val($sformatf("vec%0d.out_data", i),  32'(out_data),  32'(vecs[i].e_data));
            check_val($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ready));
            check_val($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
        end
        check_output("after_table");

        // Asynchronous reset mid-stream with three entries and overflow set
        apply_stimulus(1'b0, 1'b1, 9'h011, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h022, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h033, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h044, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h077, 1'b0);
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b1);
        check_output("pre_flush");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        flush_n = 1'b0;
        #1;
        check_val("flush.count",     32'(count),     32'd0);
        check_val("flush.out_valid", 32'(out_valid), 32'd0);
        check_val("flush.out_data",  32'(out_data),  32'd0);
        check_val("flush.in_ready",  32'(in_ready),  32'd1);
        check_val("flush.overflow",  32'(overflow),  32'd0);
        model_reset();
        @(negedge clk);
        flush_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 9'h0AA, 1'b0);
        check_output("first_after_flush");
        check_val("first_after_flush.data", 32'(out_data), 32'h0AA);

        // Simultaneous push and pop at count 2 across pointer wrap
        apply_stimulus(1'b0, 1'b1, 9'h0AB, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, WIDTH'(9'h100 + i), 1'b1);
            check_output($sformatf("simul%0d", i));
            check_val($sformatf("simul%0d.count2", i), 32'(count), 32'd2);
        end

        // Clear priority at count 3 with overflow set
        apply_stimulus(1'b0, 1'b1, 9'h0C1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h0C2, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h0C3, 1'b0);
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b1);
        check_output("pre_clr");
        apply_stimulus(1'b1, 1'b1, 9'h0C4, 1'b1);
        check_val("clr.count",     32'(count),     32'd0);
        check_val("clr.overflow",  32'(overflow),  32'd0);
        check_val("clr.out_valid", 32'(out_valid), 32'd0);
        check_output("post_clr");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 31) == 0),
                           $urandom_range(0, 1) == 1,
                           WIDTH'($urandom),
                           $urandom_range(0, 2) != 0);
            check_output($sformatf("rand%0d", i));
        end

`ifdef RESULT_FIFO_ACCUM_EN
        // 200 pops of 0x1FF must wrap the accumulator to 36664
        apply_stimulus(1'b1, 1'b0, 9'h000, 1'b0);
        apply_stimulus(1'b0, 1'b1, 9'h1FF, 1'b0);
        for (int i = 0; i < 199; i++) begin
            apply_stimulus(1'b0, 1'b1, 9'h1FF, 1'b1);
        end
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b1);
        check_val("accum.acc", 32'(acc), 32'd36664);
        check_output("accum");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
